// File: rtl/ws_pe_dbuf.sv
// ---------------------------------------------------------------------------
// ws_pe_dbuf: weight-stationary processing element with a double-buffered
// weight. A shadow weight register forms a shift chain between PEs, so the
// next tile's weights can be preloaded while the current tile computes. A
// swap copies the shadow weight into the active weight. Each valid cycle
// computes psum_out = active_weight * act_in + psum_in, with either
// saturation or wrap-around on overflow. A sticky ovf flag records overflow.
//
// Ports
//   clk            in   clock; every register updates on the rising edge
//   reset          in   synchronous, active-high reset
//   w_shift_en     in   load w_in into the shadow weight
//   w_in           in   [WBITS]  shadow-chain input from the upstream PE
//   w_out          out  [WBITS]  shadow-chain output (the shadow register)
//   w_swap         in   copy the shadow weight into the active weight
//   act_in         in   [WBITS]  activation from the west neighbour
//   act_valid_in   in   act_in and psum_in are valid
//   act_out        out  [WBITS]  registered activation to the east
//   act_valid_out  out  registered act_valid_in
//   psum_in        in   [ABITS]  partial sum from the north neighbour
//   psum_out       out  [ABITS]  registered partial sum to the south
//   psum_valid_out out  psum_out holds a fresh result
//   ovf            out  sticky overflow flag
//   ovf_clr        in   clear ovf (a simultaneous overflow wins)
// ---------------------------------------------------------------------------
module ws_pe_dbuf #(
    parameter int WBITS    = 8,
    parameter int ABITS    = 24,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_shift_en,
    input  logic [WBITS-1:0] w_in,
    output logic [WBITS-1:0] w_out,
    input  logic             w_swap,
    input  logic [WBITS-1:0] act_in,
    input  logic             act_valid_in,
    output logic [WBITS-1:0] act_out,
    output logic             act_valid_out,
    input  logic [ABITS-1:0] psum_in,
    output logic [ABITS-1:0] psum_out,
    output logic             psum_valid_out,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int   PW       = 2 * WBITS;  // full product width
    localparam int   SW       = ABITS + 1;  // sum width, one guard bit
    localparam logic SIGN_EXT = (SIGNED != 0);
    localparam logic SAT_EN   = (SATURATE != 0);

    if (ABITS < 2 * WBITS) begin : g_bad_abits
        $error("ws_pe_dbuf: ABITS must be at least 2*WBITS");
    end

    logic [WBITS-1:0] w_shadow_reg;
    logic [WBITS-1:0] w_active_reg;
    logic [WBITS-1:0] act_reg;
    logic             act_valid_reg;
    logic [ABITS-1:0] psum_reg;
    logic             psum_valid_reg;
    logic             ovf_reg;

    logic [PW-1:0]    w_ext;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    prod;
    logic [SW-1:0]    prod_ext;
    logic [SW-1:0]    psum_ext;
    logic [SW-1:0]    sum;
    logic             ovf_event;
    logic [ABITS-1:0] result_next;

    // Datapath. Both operands are extended to the full product width first,
    // so a plain PW x PW multiply truncated to PW bits yields the correct
    // product for signed and unsigned operands alike.
    always_comb begin
        w_ext    = {{WBITS{SIGN_EXT & w_active_reg[WBITS-1]}}, w_active_reg};
        a_ext    = {{WBITS{SIGN_EXT & act_in[WBITS-1]}}, act_in};
        prod     = w_ext * a_ext;
        prod_ext = {{(SW - PW){SIGN_EXT & prod[PW-1]}}, prod};
        psum_ext = {SIGN_EXT & psum_in[ABITS-1], psum_in};
        sum      = prod_ext + psum_ext;

        // The exact sum always fits in ABITS+1 bits. Signed: overflow when
        // the guard bit disagrees with the ABITS-bit sign. Unsigned: any
        // carry into the guard bit.
        if (SIGN_EXT) begin
            ovf_event = sum[ABITS] ^ sum[ABITS-1];
        end else begin
            ovf_event = sum[ABITS];
        end

        result_next = sum[ABITS-1:0];
        if (ovf_event && SAT_EN) begin
            if (SIGN_EXT) begin
                // Guard bit carries the true sign of the exact sum.
                result_next = sum[ABITS] ? {1'b1, {(ABITS-1){1'b0}}}
                                         : {1'b0, {(ABITS-1){1'b1}}};
            end else begin
                result_next = {ABITS{1'b1}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_shadow_reg   <= '0;
            w_active_reg   <= '0;
            act_reg        <= '0;
            act_valid_reg  <= 1'b0;
            psum_reg       <= '0;
            psum_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            // Shift and swap run regardless of act_valid_in so the next
            // tile can preload during compute. A simultaneous shift+swap
            // moves the old shadow value into the active register.
            if (w_shift_en) begin
                w_shadow_reg <= w_in;
            end
            if (w_swap) begin
                w_active_reg <= w_shadow_reg;
            end

            act_valid_reg  <= act_valid_in;
            psum_valid_reg <= act_valid_in;
            if (act_valid_in) begin
                act_reg  <= act_in;
                psum_reg <= result_next;
            end

            // Set has priority over clear.
            if (act_valid_in && ovf_event) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign w_out          = w_shadow_reg;
    assign act_out        = act_reg;
    assign act_valid_out  = act_valid_reg;
    assign psum_out       = psum_reg;
    assign psum_valid_out = psum_valid_reg;
    assign ovf            = ovf_reg;

endmodule

// File: doc/ws_pe_dbuf.md
WS_PE_DBUF -- requirements
Module: ws_pe_dbuf

Interface
REQ-001 Parameter WBITS, default 8, width of weights and activations.
REQ-002 Parameter ABITS, default 24, width of partial sums; legal only when ABITS >= 2*WBITS.
REQ-003 Parameter SIGNED, default 1; 1 = two's-complement operands and sums, 0 = unsigned.
REQ-004 Parameter SATURATE, default 1; 1 = clamp partial sum on overflow, 0 = wrap modulo 2^ABITS.
REQ-005 Port clk  in  1  clock; all state updates on its rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port w_shift_en  in  1  shift the shadow-weight chain this cycle.
REQ-008 Port w_in  in  WBITS  shadow-chain input from the upstream PE.
REQ-009 Port w_out  out  WBITS  shadow-chain output; equals the shadow register.
REQ-010 Port w_swap  in  1  copy shadow weight into active weight.
REQ-011 Port act_in  in  WBITS  activation from the west neighbour.
REQ-012 Port act_valid_in  in  1  act_in and psum_in are valid.
REQ-013 Port act_out  out  WBITS  registered activation to the east neighbour.
REQ-014 Port act_valid_out  out  1  registered act_valid_in.
REQ-015 Port psum_in  in  ABITS  partial sum from the north neighbour.
REQ-016 Port psum_out  out  ABITS  registered partial sum to the south neighbour.
REQ-017 Port psum_valid_out  out  1  psum_out is valid.
REQ-018 Port ovf  out  1  sticky flag: a saturation or wrap event occurred.
REQ-019 Port ovf_clr  in  1  clears ovf.

Function
REQ-020 Shadow register: on w_shift_en=1 it loads w_in; otherwise it holds.
REQ-021 Active register: on w_swap=1 it loads the shadow register's pre-edge value; otherwise it holds.
REQ-022 Simultaneous w_shift_en and w_swap: active gets the old shadow value and shadow gets w_in, in the same edge.
REQ-023 Weight shift and swap are independent of act_valid_in; preload of the next tile overlaps compute without stalls.
REQ-024 MAC: result = active_weight * act_in + psum_in.
- Active weight is the pre-edge value.
- A swap in the same cycle affects only later cycles.
REQ-025 Arithmetic width:
- Product is full 2*WBITS.
- Product is sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ABITS+1.
- psum_in is extended the same way.
- The sum is computed in ABITS+1 bits.
REQ-026 Overflow detection:
- SIGNED=1: the exact sum falls outside [-2^(ABITS-1), 2^(ABITS-1)-1].
- SIGNED=0: the exact sum is >= 2^ABITS.
REQ-027 SATURATE=1 on overflow: psum_out takes the nearest bound (signed max/min, or unsigned all-ones).
REQ-028 SATURATE=0 on overflow: psum_out takes the low ABITS bits.
REQ-029 Valid cycle (act_valid_in=1): psum_out <= result, psum_valid_out <= 1, act_out <= act_in, act_valid_out <= 1; latency exactly 1 cycle.
REQ-030 Idle cycle (act_valid_in=0): psum_out and act_out hold their values; psum_valid_out <= 0; act_valid_out <= 0.
REQ-031 ovf sets on the edge where a valid cycle overflows.
REQ-032 ovf_clr=1 clears ovf; if an overflow occurs in the same cycle, set wins.
REQ-033 No combinational path from any input to any output.

Reset
REQ-034 reset=1 clears shadow weight, active weight, act_out, act_valid_out, psum_out, psum_valid_out and ovf to 0 on the next edge.
REQ-035 reset has priority over w_shift_en, w_swap, act_valid_in and ovf_clr.
REQ-036 Reset asserted mid-stream discards the in-flight result; the first valid cycle after release uses active weight 0.

Verification
REQ-037 Preload/swap: shift 3, then 5, through a 2-PE chain, then swap both -> active weights are 5 (first PE) and 3 (second PE); w_out of the first PE is 5.
REQ-038 Overlap: active weight 4, shift shadow to 9 while feeding act_in=2, psum_in=10 -> psum_out=18; after a swap the same inputs give psum_out=28.
REQ-039 Signed saturation (WBITS=8, ABITS=16, SIGNED=1, SATURATE=1): weight 127, act 127, psum_in 32767 -> psum_out=32767, ovf=1; weight -128, act 127, psum_in -32768 -> psum_out=-32768.
REQ-040 Wrap mode (SATURATE=0, SIGNED=0, ABITS=16): weight 255, act 255, psum_in 65535 -> psum_out=0xFE00, ovf=1; ovf_clr in the next idle cycle -> ovf=0.
REQ-041 Idle hold: valid result 18, then act_valid_in=0 for 3 cycles -> psum_out stays 18 and psum_valid_out=0.
REQ-042 Reset mid-stream: reset asserted during a valid cycle -> all outputs 0 next cycle, ovf=0, active weight 0.
